// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / flush / freeze hazard controller for a 5-stage pipe.
// Decodes each cycle into NORMAL, STALL, FLUSH or FREEZE and counts each event type.
module pipeline_hazard_ctrl #(
    parameter int LOAD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_rd_ex,
    input  logic [4:0]  Rd_ex,
    input  logic [4:0]  Rs1_id,
    input  logic [4:0]  Rs2_id,
    input  logic        Rs1_used,
    input  logic        Rs2_used,
    input  logic        Flush_req,
    input  logic        Mem_busy,
    output logic        PC_wr,
    output logic        IF_ID_wr,
    output logic        ID_EX_wr,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic [15:0] Stall_cnt,
    output logic [15:0] Flush_cnt,
    output logic [15:0] Freeze_cnt
);

    typedef enum logic {RUN, STALL} state_e;

    localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [15:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    logic hazard;
    logic frz_ev, fls_ev, stl_ev;

    assign hazard = Mem_rd_ex && (Rd_ex != 5'd0) &&
                    ((Rs1_used && (Rs1_id == Rd_ex)) || (Rs2_used && (Rs2_id == Rd_ex)));

    // Cycle classification in priority order; nothing fires while reset is held.
    assign frz_ev = reset && Mem_busy;
    assign fls_ev = reset && !Mem_busy && (pend_q || Flush_req);
    assign stl_ev = reset && !Mem_busy && !(pend_q || Flush_req) &&
                    ((state_q == STALL) || hazard);

    always_comb begin
        PC_wr       = 1'b1;
        IF_ID_wr    = 1'b1;
        ID_EX_wr    = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        if (frz_ev) begin
            PC_wr    = 1'b0;
            IF_ID_wr = 1'b0;
            ID_EX_wr = 1'b0;
        end else if (fls_ev) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (stl_ev) begin
            PC_wr       = 1'b0;
            IF_ID_wr    = 1'b0;
            ID_EX_flush = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        if (frz_ev) begin
            pend_d = pend_q || Flush_req;
        end else if (fls_ev) begin
            pend_d  = 1'b0;
            cnt_d   = 2'd0;
            state_d = RUN;
        end else if (stl_ev) begin
            if (state_q == STALL) begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) state_d = RUN;
            end else if (LOAD_LAT > 1) begin
                // Detection cycle is the first bubble; the rest come from STALL.
                state_d = STALL;
                cnt_d   = LAT_M1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            cnt_q        <= 2'd0;
            pend_q       <= 1'b0;
            stall_cnt_q  <= 16'd0;
            flush_cnt_q  <= 16'd0;
            freeze_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            if (stl_ev && stall_cnt_q != 16'hFFFF)  stall_cnt_q  <= stall_cnt_q + 16'd1;
            if (fls_ev && flush_cnt_q != 16'hFFFF)  flush_cnt_q  <= flush_cnt_q + 16'd1;
            if (frz_ev && freeze_cnt_q != 16'hFFFF) freeze_cnt_q <= freeze_cnt_q + 16'd1;
        end
    end

    assign Stall_cnt  = stall_cnt_q;
    assign Flush_cnt  = flush_cnt_q;
    assign Freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: directed stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
// Two instances (LOAD_LAT=1 and 3) share the inputs; each entry selects which one it checks.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Mem_rd_ex = 1'b0, Rs1_used = 1'b0, Rs2_used = 1'b0;
    logic       Flush_req = 1'b0, Mem_busy = 1'b0;
    logic [4:0] Rd_ex = 5'd0, Rs1_id = 5'd0, Rs2_id = 5'd0;

    logic        pc1, ifw1, idw1, iff1, idf1, pc3, ifw3, idw3, iff3, idf3;
    logic [15:0] s1, f1, z1, s3, f3, z3;

    localparam logic [4:0] NORM = 5'b11100;
    localparam logic [4:0] STL  = 5'b00101;
    localparam logic [4:0] FLS  = 5'b11111;
    localparam logic [4:0] FRZ  = 5'b00000;

    typedef struct {
        int          which;
        logic [4:0]  out;
        logic [15:0] s, f, z;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.LOAD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .Mem_rd_ex(Mem_rd_ex), .Rd_ex(Rd_ex),
        .Rs1_id(Rs1_id), .Rs2_id(Rs2_id), .Rs1_used(Rs1_used), .Rs2_used(Rs2_used),
        .Flush_req(Flush_req), .Mem_busy(Mem_busy),
        .PC_wr(pc1), .IF_ID_wr(ifw1), .ID_EX_wr(idw1), .IF_ID_flush(iff1), .ID_EX_flush(idf1),
        .Stall_cnt(s1), .Flush_cnt(f1), .Freeze_cnt(z1));

    pipeline_hazard_ctrl #(.LOAD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .Mem_rd_ex(Mem_rd_ex), .Rd_ex(Rd_ex),
        .Rs1_id(Rs1_id), .Rs2_id(Rs2_id), .Rs1_used(Rs1_used), .Rs2_used(Rs2_used),
        .Flush_req(Flush_req), .Mem_busy(Mem_busy),
        .PC_wr(pc3), .IF_ID_wr(ifw3), .ID_EX_wr(idw3), .IF_ID_flush(iff3), .ID_EX_flush(idf3),
        .Stall_cnt(s3), .Flush_cnt(f3), .Freeze_cnt(z3));

    task automatic chk(input string name, input int lat, input logic [4:0] got_o, input logic [4:0] exp_o,
                       input logic [47:0] got_c, input logic [47:0] exp_c);
        n_checks++;
        if (got_o !== exp_o) begin
            n_fail++;
            $display("FAIL %s lat%0d outputs got=%b want=%b at %0t", name, lat, got_o, exp_o, $time);
        end
        n_checks++;
        if (got_c !== exp_c) begin
            n_fail++;
            $display("FAIL %s lat%0d counters(stall,flush,freeze) got=%h want=%h at %0t",
                     name, lat, got_c, exp_c, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.which != 3)
                chk(e.name, 1, {pc1, ifw1, idw1, iff1, idf1}, e.out, {s1, f1, z1}, {e.s, e.f, e.z});
            if (e.which != 1)
                chk(e.name, 3, {pc3, ifw3, idw3, iff3, idf3}, e.out, {s3, f3, z3}, {e.s, e.f, e.z});
        end
    end

    task automatic push(input string name, input int which, input logic [4:0] out,
                        input logic [15:0] s, input logic [15:0] f, input logic [15:0] z);
        exp_t e;
        e.name = name; e.which = which; e.out = out; e.s = s; e.f = f; e.z = z;
        sbq.push_back(e);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Mem_rd_ex = 1'b0; Rd_ex = 5'd0; Rs1_id = 5'd0; Rs2_id = 5'd0;
        Rs1_used = 1'b0; Rs2_used = 1'b0; Flush_req = 1'b0; Mem_busy = 1'b0;
    endtask

    task automatic load_use();
        Mem_rd_ex = 1'b1; Rd_ex = 5'd5; Rs1_id = 5'd5; Rs1_used = 1'b1;
    endtask

    // Reset held with every hazard-ish input active: outputs must stay NORMAL.
    task automatic do_reset();
        nxt(); reset = 1'b0; load_use(); Flush_req = 1'b1; Mem_busy = 1'b1;
        push("reset_hold", 0, NORM, 0, 0, 0);
        nxt(); push("reset_hold", 0, NORM, 0, 0, 0);
        nxt(); reset = 1'b1; clr(); push("reset_release", 0, NORM, 0, 0, 0);
    endtask

    initial begin
        clr();

        // Single-bubble load-use on the LOAD_LAT=1 instance
        do_reset();
        nxt(); load_use(); push("lu_lat1", 1, STL, 0, 0, 0);
        nxt(); clr();      push("lu_lat1_after", 1, NORM, 1, 0, 0);
        nxt();             push("lu_lat1_after", 1, NORM, 1, 0, 0);

        // Three bubbles on LOAD_LAT=3
        do_reset();
        nxt(); load_use(); push("lu_lat3_c1", 3, STL, 0, 0, 0);
        nxt(); clr();      push("lu_lat3_c2", 3, STL, 1, 0, 0);
        nxt();             push("lu_lat3_c3", 3, STL, 2, 0, 0);
        nxt();             push("lu_lat3_done", 3, NORM, 3, 0, 0);
        nxt();             push("lu_lat3_done", 3, NORM, 3, 0, 0);

        // Flush aborts a stall in its second cycle
        do_reset();
        nxt(); load_use();      push("fl_stall_c1", 3, STL, 0, 0, 0);
        nxt(); clr(); Flush_req = 1'b1; push("fl_stall_flush", 3, FLS, 1, 0, 0);
        nxt(); clr();           push("fl_stall_after", 3, NORM, 1, 1, 0);
        nxt();                  push("fl_stall_after", 3, NORM, 1, 1, 0);

        // Flush requested during a freeze is held until the freeze ends
        do_reset();
        nxt(); Mem_busy = 1'b1;  push("fl_frz_c1", 3, FRZ, 0, 0, 0);
        nxt(); Flush_req = 1'b1; push("fl_frz_c2", 3, FRZ, 0, 0, 1);
        nxt(); Flush_req = 1'b0; push("fl_frz_c3", 3, FRZ, 0, 0, 2);
        nxt();                   push("fl_frz_c4", 3, FRZ, 0, 0, 3);
        nxt(); Mem_busy = 1'b0;  push("fl_frz_pend", 3, FLS, 0, 0, 4);
        nxt();                   push("fl_frz_after", 3, NORM, 0, 1, 4);

        // Freeze interleaved in a stall does not consume a bubble
        do_reset();
        nxt(); load_use();       push("stl_frz_c1", 3, STL, 0, 0, 0);
        nxt(); clr(); Mem_busy = 1'b1; push("stl_frz_frz", 3, FRZ, 1, 0, 0);
        nxt(); Mem_busy = 1'b0;  push("stl_frz_c2", 3, STL, 1, 0, 1);
        nxt();                   push("stl_frz_c3", 3, STL, 2, 0, 1);
        nxt();                   push("stl_frz_done", 3, NORM, 3, 0, 1);

        // Hazard qualification: x0, unused source, non-load, Rs2 match
        do_reset();
        nxt(); Mem_rd_ex = 1'b1; Rd_ex = 5'd0; Rs1_used = 1'b1; Rs2_used = 1'b1;
        push("x0_no_stall", 3, NORM, 0, 0, 0);
        nxt(); Rd_ex = 5'd7; Rs1_id = 5'd7; Rs1_used = 1'b0; Rs2_id = 5'd3;
        push("unused_src", 3, NORM, 0, 0, 0);
        nxt(); Mem_rd_ex = 1'b0; Rs1_used = 1'b1;
        push("not_load", 3, NORM, 0, 0, 0);
        nxt(); Mem_rd_ex = 1'b1; Rs1_id = 5'd2; Rs2_id = 5'd7;
        push("rs2_hazard", 3, STL, 0, 0, 0);
        nxt(); clr(); push("rs2_c2", 3, STL, 1, 0, 0);
        nxt();        push("rs2_c3", 3, STL, 2, 0, 0);
        nxt();        push("rs2_done", 3, NORM, 3, 0, 0);

        // Async reset between edges mid-stall, then no residual bubbles
        do_reset();
        nxt(); load_use(); push("rst_stall_c1", 0, STL, 0, 0, 0);
        nxt(); clr();      push("rst_stall_c2", 3, STL, 1, 0, 0);
        nxt(); reset = 1'b0; push("rst_async", 0, NORM, 0, 0, 0);
        nxt(); reset = 1'b1; push("rst_rel", 0, NORM, 0, 0, 0);
        nxt();               push("rst_no_resid", 0, NORM, 0, 0, 0);

        // Async reset discards a flush pended during freeze
        do_reset();
        nxt(); Mem_busy = 1'b1; Flush_req = 1'b1; push("rst_pend_frz", 0, FRZ, 0, 0, 0);
        nxt(); clr(); reset = 1'b0; push("rst_pend_async", 0, NORM, 0, 0, 0);
        nxt(); reset = 1'b1;        push("rst_pend_rel", 0, NORM, 0, 0, 0);
        nxt();                      push("rst_pend_gone", 0, NORM, 0, 0, 0);

        // Freeze counter saturation
        do_reset();
        for (int k = 1; k <= 70000; k++) begin
            nxt(); Mem_busy = 1'b1;
            push("sat_freeze", 3, FRZ, 0, 0, (k - 1 > 65535) ? 16'hFFFF : 16'(k - 1));
        end
        nxt(); Mem_busy = 1'b0; push("sat_hold", 3, NORM, 0, 0, 16'hFFFF);
        nxt();                  push("sat_hold", 3, NORM, 0, 0, 16'hFFFF);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain scoreboard left=%0d want=0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
